// File: rtl/keypad_event_ctrl_if.sv
// Key-event handshake between keypad_event_ctrl (master) and its consumer
// (slave). One 5-bit event moves per cycle in which ev_valid & ev_ready.
//   ev_valid : head event present (FIFO non-empty)
//   ev_code  : {press, key_idx[3:0]}; forced to 0 when ev_valid = 0
//   ev_ready : consumer accepts the head event
interface keypad_event_ctrl_if;
  logic       ev_valid;
  logic [4:0] ev_code;
  logic       ev_ready;

  modport master (output ev_valid, ev_code, input  ev_ready);
  modport slave  (input  ev_valid, ev_code, output ev_ready);
endinterface

// File: rtl/keypad_event_ctrl.sv
// keypad_event_ctrl: paces a 4x4 keypad scanner, turns the 16 debounced key
// levels into press/release events and queues them for a consumer.
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   enable_i    : 1 = divider runs; 0 = divider held at 0, no tick
//   keys_i      : debounced key levels, bit i = key code i, 1 = pressed
//   scan_tick_o : one-cycle pulse every CLK_DIV clocks (column advance)
//   key_any_o   : registered OR of the sampled key levels
//   overflow_o  : sticky, set when an edge merged into a pending one
//   ovf_clr_i   : clears overflow_o (a same-cycle loss keeps it set)
//   ev_if       : event handshake (master side)

// Per-key slice: two-stage sampler, edge detect and the press/release
// pending bits for a single key.
module keypad_key_slice (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  input  logic grant_p_i,
  input  logic grant_r_i,
  output logic k1_o,
  output logic pp_o,
  output logic pr_o,
  output logic lost_o
);
  logic k1_q, k2_q, pp_q, pr_q;
  logic rise, fall;

  assign rise = k1_q & ~k2_q;
  assign fall = ~k1_q & k2_q;

  // An edge landing on a still-pending bit of the same kind merges with it;
  // a bit being granted this cycle has already left, so nothing is lost.
  assign lost_o = (rise & pp_q & ~grant_p_i) | (fall & pr_q & ~grant_r_i);

  assign k1_o = k1_q;
  assign pp_o = pp_q;
  assign pr_o = pr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k1_q <= 1'b0;
      k2_q <= 1'b0;
      pp_q <= 1'b0;
      pr_q <= 1'b0;
    end else begin
      k1_q <= key_i;
      k2_q <= k1_q;
      pp_q <= (pp_q & ~grant_p_i) | rise;
      pr_q <= (pr_q & ~grant_r_i) | fall;
    end
  end
endmodule

module keypad_event_ctrl #(
  parameter int CLK_DIV = 50000,
  parameter int DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic [15:0]         keys_i,
  output logic                scan_tick_o,
  output logic                key_any_o,
  output logic                overflow_o,
  input  logic                ovf_clr_i,
  keypad_event_ctrl_if.master ev_if
);
  localparam int NUM_KEYS = 16;
  localparam int CW       = $clog2(CLK_DIV);
  localparam int AW       = $clog2(DEPTH);

  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DIV_ONE  = CW'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // ---------------- scan divider ----------------
  logic [CW-1:0] div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                div_q <= '0;
    else if (!enable_i)        div_q <= '0;
    else if (div_q == DIV_LAST) div_q <= '0;
    else                       div_q <= div_q + DIV_ONE;
  end

  assign scan_tick_o = enable_i & (div_q == DIV_LAST);

  // ---------------- per-key sampling / pending ----------------
  logic [NUM_KEYS-1:0] k1, pp, pr, lost, grant_p, grant_r;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    keypad_key_slice u_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_i    (keys_i[g]),
      .grant_p_i(grant_p[g]),
      .grant_r_i(grant_r[g]),
      .k1_o     (k1[g]),
      .pp_o     (pp[g]),
      .pr_o     (pr[g]),
      .lost_o   (lost[g])
    );
  end

  // ---------------- selector ----------------
  logic [AW:0]   cnt_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [DEPTH-1:0][4:0] mem_q;

  logic       has_room, push, pop, p_any, r_any;
  logic [3:0] p_idx, r_idx;
  logic [4:0] push_code;

  assign p_any = |pp;
  assign r_any = |pr;

  // Lowest set index wins: scan downward so the last hit is the lowest.
  always_comb begin
    p_idx = '0;
    r_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pp[i]) p_idx = 4'(i);
      if (pr[i]) r_idx = 4'(i);
    end
  end

  // Room is judged on the count at the start of the cycle, so a pop from a
  // full FIFO does not open a slot until the next cycle.
  assign has_room  = (cnt_q < CNT_FULL);
  assign push      = has_room & (p_any | r_any);
  assign push_code = p_any ? {1'b1, p_idx} : {1'b0, r_idx};
  assign grant_p   = (push & p_any)  ? (16'd1 << p_idx) : '0;
  assign grant_r   = (push & ~p_any) ? (16'd1 << r_idx) : '0;

  // ---------------- event FIFO (first-word fall-through) ----------------
  assign ev_if.ev_valid = (cnt_q != '0);
  assign ev_if.ev_code  = ev_if.ev_valid ? mem_q[rd_q] : 5'd0;
  assign pop            = ev_if.ev_valid & ev_if.ev_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_code;
        wr_q        <= wr_q + PTR_ONE;
      end
      if (pop) rd_q <= rd_q + PTR_ONE;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------- status flags ----------------
  logic key_any_q, overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_any_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      key_any_q <= |k1;
      if (|lost)          overflow_q <= 1'b1;
      else if (ovf_clr_i) overflow_q <= 1'b0;
    end
  end

  assign key_any_o  = key_any_q;
  assign overflow_o = overflow_q;
endmodule

// File: tb/tb_keypad_event_ctrl.sv
module tb_keypad_event_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] keys;
  logic        scan_tick, key_any, overflow, ovf_clr;
  int          vectors = 0;
  int          miscompares = 0;

  keypad_event_ctrl_if ev_if ();

  keypad_event_ctrl #(.CLK_DIV(4), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable),
    .keys_i     (keys),
    .scan_tick_o(scan_tick),
    .key_any_o  (key_any),
    .overflow_o (overflow),
    .ovf_clr_i  (ovf_clr),
    .ev_if      (ev_if.master)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b1; keys = '0; ovf_clr = 1'b0; ev_if.ev_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({scan_tick, ev_if.ev_valid, ev_if.ev_code, key_any, overflow} !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got tick=%b valid=%b code=%h any=%b ovf=%b, want all 0",
               scan_tick, ev_if.ev_valid, ev_if.ev_code, key_any, overflow);
    end
  endtask

  task automatic test_divider;
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      vectors++;
      if (scan_tick !== (c % 4 == 0)) begin
        miscompares++;
        $display("FAIL tick_after_reset c=%0d: got %b want %b", c, scan_tick, (c % 4 == 0));
      end
      vectors++;
      if (ev_if.ev_valid !== 1'b0 || key_any !== 1'b0 || overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_outputs c=%0d: got valid=%b any=%b ovf=%b want 0", c,
                 ev_if.ev_valid, key_any, overflow);
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (scan_tick !== 1'b0) begin
        miscompares++;
        $display("FAIL tick_disabled c=%0d: got %b want 0", c, scan_tick);
      end
      @(negedge clk);
    end
    enable = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      vectors++;
      if (scan_tick !== (c % 4 == 0)) begin
        miscompares++;
        $display("FAIL tick_after_enable c=%0d: got %b want %b", c, scan_tick, (c % 4 == 0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_press_release;
    ev_if.ev_ready = 1'b1;
    keys = 16'h0020;
    for (int s = 1; s <= 5; s++) begin
      @(negedge clk);
      vectors++;
      if (ev_if.ev_valid !== (s == 3) || key_any !== (s >= 2)) begin
        miscompares++;
        $display("FAIL press5 s=%0d: got valid=%b any=%b want valid=%b any=%b", s,
                 ev_if.ev_valid, key_any, (s == 3), (s >= 2));
      end
      if (s == 3) begin
        vectors++;
        if (ev_if.ev_code !== 5'h15) begin
          miscompares++;
          $display("FAIL press5_code: got %h want 15", ev_if.ev_code);
        end
      end
    end
    keys = 16'h0000;
    for (int s = 1; s <= 4; s++) begin
      @(negedge clk);
      vectors++;
      if (ev_if.ev_valid !== (s == 3) || key_any !== (s == 1)) begin
        miscompares++;
        $display("FAIL release5 s=%0d: got valid=%b any=%b want valid=%b any=%b", s,
                 ev_if.ev_valid, key_any, (s == 3), (s == 1));
      end
      if (s == 3) begin
        vectors++;
        if (ev_if.ev_code !== 5'h05) begin
          miscompares++;
          $display("FAIL release5_code: got %h want 05", ev_if.ev_code);
        end
      end
    end
  endtask

  task automatic test_two_keys;
    logic [4:0] exp [4];
    exp[0] = 5'h10; exp[1] = 5'h1F; exp[2] = 5'h00; exp[3] = 5'h0F;
    ev_if.ev_ready = 1'b0;
    keys = 16'h8001;
    repeat (3) @(negedge clk);
    vectors++;
    if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 5'h10) begin
      miscompares++;
      $display("FAIL two_keys_first: got valid=%b code=%h want 1/10", ev_if.ev_valid, ev_if.ev_code);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (ev_if.ev_code !== 5'h10) begin
      miscompares++;
      $display("FAIL two_keys_stable: got %h want 10", ev_if.ev_code);
    end
    keys = 16'h0000;
    repeat (5) @(negedge clk);
    ev_if.ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== exp[i]) begin
        miscompares++;
        $display("FAIL two_keys_drain i=%0d: got valid=%b code=%h want 1/%h", i,
                 ev_if.ev_valid, ev_if.ev_code, exp[i]);
      end
      @(negedge clk);
    end
    vectors++;
    if (ev_if.ev_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL two_keys_empty: got valid=%b want 0", ev_if.ev_valid);
    end
  endtask

  task automatic test_full_pending;
    logic [4:0] exp [6];
    exp[0] = 5'h11; exp[1] = 5'h12; exp[2] = 5'h14;
    exp[3] = 5'h17; exp[4] = 5'h19; exp[5] = 5'h1C;
    ev_if.ev_ready = 1'b0;
    keys = 16'h1296;
    repeat (10) @(negedge clk);
    vectors++;
    if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 5'h11 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL full_head: got valid=%b code=%h ovf=%b want 1/11/0",
               ev_if.ev_valid, ev_if.ev_code, overflow);
    end
    ev_if.ev_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== exp[i]) begin
        miscompares++;
        $display("FAIL full_drain i=%0d: got valid=%b code=%h want 1/%h", i,
                 ev_if.ev_valid, ev_if.ev_code, exp[i]);
      end
      @(negedge clk);
    end
    vectors++;
    if (ev_if.ev_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_empty: got valid=%b want 0", ev_if.ev_valid);
    end
    keys = 16'h0000;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_overflow;
    logic [4:0] exp [6];
    exp[0] = 5'h1C; exp[1] = 5'h1D; exp[2] = 5'h1E;
    exp[3] = 5'h1F; exp[4] = 5'h13; exp[5] = 5'h03;
    ev_if.ev_ready = 1'b0;
    keys = 16'hF000;
    repeat (7) @(negedge clk);
    keys = 16'hF008; repeat (2) @(negedge clk);
    keys = 16'hF000; repeat (2) @(negedge clk);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_before_repress: got %b want 0", overflow);
    end
    keys = 16'hF008;
    repeat (3) @(negedge clk);
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set: got %b want 1", overflow);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: got %b want 0", overflow);
    end
    ev_if.ev_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== exp[i]) begin
        miscompares++;
        $display("FAIL ovf_drain i=%0d: got valid=%b code=%h want 1/%h", i,
                 ev_if.ev_valid, ev_if.ev_code, exp[i]);
      end
      @(negedge clk);
    end
    vectors++;
    if (ev_if.ev_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_empty: got valid=%b want 0", ev_if.ev_valid);
    end
    keys = 16'h0000;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_async_reset;
    ev_if.ev_ready = 1'b0;
    keys = 16'h0003;
    repeat (5) @(negedge clk);
    vectors++;
    if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 5'h10) begin
      miscompares++;
      $display("FAIL queued_before_reset: got valid=%b code=%h want 1/10", ev_if.ev_valid, ev_if.ev_code);
    end
    #2 rst_n = 1'b0;
    keys = 16'h0004;
    #1;
    vectors++;
    if (ev_if.ev_valid !== 1'b0 || ev_if.ev_code !== 5'h00) begin
      miscompares++;
      $display("FAIL async_reset: got valid=%b code=%h want 0/00", ev_if.ev_valid, ev_if.ev_code);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 5'h12) begin
      miscompares++;
      $display("FAIL held_key_after_reset: got valid=%b code=%h want 1/12", ev_if.ev_valid, ev_if.ev_code);
    end
    ev_if.ev_ready = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      vectors++;
      if (ev_if.ev_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL single_event s=%0d: got valid=%b want 0", s, ev_if.ev_valid);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_press_release();
    test_two_keys();
    test_full_pending();
    test_overflow();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/keypad_event_ctrl.md
# keypad_event_ctrl

Controller for the 4x4 matrix keypad scanner and its 16 debounced key outputs. It generates the column-advance tick that paces the scanner and detects press and release edges on the 16 key levels. It serialises those edges into a small FIFO of 5-bit key events and hands them to the consumer (display or UART logic) over a valid/ready handshake. It also flags lost events and reports whether any key is held.

## Interface
- CLK_DIV, default 50000: scan tick period in clocks; legal range 2..2^20.
- DEPTH, default 4: event FIFO depth; power of 2, range 2..16.
- clk  in  1: system clock; all logic on the rising edge.
- rst  in  1: asynchronous, active-low reset.
- enable  in  1: 1 = scanning runs; 0 = scan_tick held 0 and the divider held at 0.
- keys  in  16: debounced key levels from the scanner; 1 = pressed; bit i = key code i.
- scan_tick  out  1: one-cycle pulse every CLK_DIV clocks while enable=1; it advances the scanner's column drive.
- ev_valid  out  1: FIFO non-empty.
- ev_code  out  5: head event; [4] = 1 for press, 0 for release; [3:0] = key index. It is 0 when ev_valid=0.
- ev_ready  in  1: consumer accepts the head event when ev_valid & ev_ready.
- key_any  out  1: registered OR of keys.
- overflow  out  1: sticky flag for a lost event.
- ovf_clr  in  1: clears overflow. A new loss in the same cycle wins.

## Operation
- Divider: counter runs 0..CLK_DIV-1. scan_tick=1 in the cycle where the counter equals CLK_DIV-1, then the counter wraps to 0. enable=0 forces the counter to 0 synchronously and suppresses the tick.
- Sampling: two registers, k1<=keys and k2<=k1.
  - rise = k1 & ~k2.
  - fall = ~k1 & k2.
  - key_any <= |k1.
- Pending masks, 16 bits each: pp (press pending) and pr (release pending).
  - Each clock: pp <= (pp & ~grant_p) | rise, and pr <= (pr & ~grant_r) | fall.
  - If a rise hits a bit already set in pp, or a fall hits a bit already set in pr, overflow <= 1. The events merge: one is delivered, one is lost.
- Selector: one push per clock at most, and only when the FIFO count < DEPTH at the start of the cycle.
  - Priority goes to any pp bit over any pr bit, then to the lowest index.
  - The grant clears exactly that pending bit and writes {1,idx} for a press or {0,idx} for a release.
  - When the FIFO is full, pending bits are held and nothing is lost.
- FIFO: first-word-fall-through with read/write pointers and a count.
  - Pop when ev_valid & ev_ready.
  - Push and pop in the same cycle are allowed when count < DEPTH, and the count is unchanged.
  - When count == DEPTH, a pop in that cycle does not enable a push; the push waits one cycle.
- Keys already held when reset releases are reported as press events, because k1 and k2 reset to 0.
- Reset (asynchronous) forces every output and register to its reset value:
  - scan_tick=0, ev_valid=0, ev_code=0, key_any=0, overflow=0.
  - Counter, k1, k2, pp, pr, pointers and count all go to 0.
  - FIFO contents are discarded.

## Timing
- Press latency: keys changes before edge E0, k1 updates at E0, pp sets at E1, and the FIFO is written at E2. ev_valid=1 after E2 when the FIFO was empty and no higher-priority event is pending.
- The handshake is standard. ev_code must stay stable while ev_valid=1 and ev_ready=0. After a pop, the next entry is visible in the following cycle.
- Sustained throughput is 1 event per clock.
- scan_tick: first pulse at clock CLK_DIV after reset release or after enable rises, then every CLK_DIV clocks.
- ovf_clr and a new overflow in the same cycle: overflow stays 1.

## Test plan
- Reset release with keys=0, CLK_DIV=4 -> scan_tick pulses at clocks 4, 8, 12. All other outputs stay 0. Dropping enable for 3 clocks shifts the next pulse to 4 clocks after enable returns.
- keys=0x0020 held 5 clocks, then 0, with ev_ready=1 -> events 0x15 (press of key 5), then 0x05 (release of key 5). ev_valid first rises 3 edges after the change. key_any follows keys with 1 cycle of delay.
- keys jumps 0 -> 0x8001 in one clock, ev_ready=0 -> FIFO holds 0x10 then 0x1F. After keys returns to 0: 0x00 then 0x0F.
- DEPTH=4, ev_ready=0, six distinct keys pressed -> FIFO holds the 4 lowest indices and 2 events stay pending with overflow=0. Raising ev_ready drains all 6 in index order.
- ev_ready=0, FIFO full, key 3 pressed, released, pressed again -> overflow=1. Exactly one 0x13 and one 0x03 are delivered. ovf_clr pulse -> overflow=0.
- Reset asserted mid-stream with 2 entries queued -> ev_valid=0 immediately (asynchronously). Releasing reset with keys=0x0004 yields a single 0x12 event.
